// File: rtl/sine_analyzer.sv
// sine_analyzer: measures a sampled tone over N full periods.
// Reports samples per N periods, signed peak max/min,
// amplitude (max-min)>>1 and DC offset (max+min)>>>1.
// Ports:
//   clk, reset_n       clock, async active-low reset
//   start              pulse; begins or restarts a run
//   num_periods        periods to measure (0 acts as 1)
//   sample_valid/data  signed sample stream
//   busy               run in progress (ARM or MEASURE)
//   done               1-cycle pulse when results update
//   timeout            last run hit the sample count limit
//   total_samples      valid samples spanning the N periods
//   max_code/min_code  signed sample extremes
//   amplitude/offset   derived from max/min
module sine_analyzer #(
    parameter int WIDTH = 12,
    parameter int CNT_W = 24,
    parameter int HYST  = 8
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [7:0]              num_periods,
    input  logic                    sample_valid,
    input  logic signed [WIDTH-1:0] sample_data,
    output logic                    busy,
    output logic                    done,
    output logic                    timeout,
    output logic [CNT_W-1:0]        total_samples,
    output logic signed [WIDTH-1:0] max_code,
    output logic signed [WIDTH-1:0] min_code,
    output logic [WIDTH-1:0]        amplitude,
    output logic signed [WIDTH-1:0] offset
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARM,
        S_MEAS
    } state_t;

    localparam logic signed [WIDTH-1:0] HYST_P  = WIDTH'(HYST);
    localparam logic signed [WIDTH-1:0] NHYST_P = -HYST_P;

    state_t                  state_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    timeout_q;
    logic                    neg_seen_q;
    logic [7:0]              n_q;
    logic [7:0]              crossing_cnt_q;
    logic [CNT_W-1:0]        sample_cnt_q;
    logic signed [WIDTH-1:0] max_q;
    logic signed [WIDTH-1:0] min_q;
    logic [CNT_W-1:0]        total_q;
    logic signed [WIDTH-1:0] res_max_q;
    logic signed [WIDTH-1:0] res_min_q;
    logic [WIDTH-1:0]        res_amp_q;
    logic signed [WIDTH-1:0] res_off_q;

    logic                    rise_d;
    logic                    nhit_d;
    logic                    close_d;
    logic                    lim_d;
    logic                    fin_meas_d;
    logic [CNT_W-1:0]        cnt_d;
    logic [7:0]              cross_d;
    logic signed [WIDTH-1:0] max_d;
    logic signed [WIDTH-1:0] min_d;
    logic [WIDTH:0]          diff_d;
    logic signed [WIDTH:0]   sum_d;
    logic [WIDTH-1:0]        amp_d;
    logic signed [WIDTH-1:0] off_d;

    always_comb begin
        rise_d  = sample_valid && neg_seen_q && (sample_data >= HYST_P);
        nhit_d  = sample_valid && (sample_data <= NHYST_P);
        cnt_d   = sample_cnt_q + CNT_W'(1);
        cross_d = crossing_cnt_q + 8'd1;
        lim_d   = &cnt_d;
        close_d = rise_d && (cross_d == n_q);
        max_d   = (sample_data > max_q) ? sample_data : max_q;
        min_d   = (sample_data < min_q) ? sample_data : min_q;
        // one extra bit keeps full-scale sums and differences exact
        diff_d  = {max_d[WIDTH-1], max_d} - {min_d[WIDTH-1], min_d};
        sum_d   = $signed({max_d[WIDTH-1], max_d})
                + $signed({min_d[WIDTH-1], min_d});
        amp_d   = WIDTH'(diff_d >> 1);
        off_d   = WIDTH'(sum_d >>> 1);
        fin_meas_d = (state_q == S_MEAS) && sample_valid
                   && (close_d || lim_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= S_IDLE;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            timeout_q      <= 1'b0;
            neg_seen_q     <= 1'b0;
            n_q            <= '0;
            crossing_cnt_q <= '0;
            sample_cnt_q   <= '0;
            max_q          <= '0;
            min_q          <= '0;
            total_q        <= '0;
            res_max_q      <= '0;
            res_min_q      <= '0;
            res_amp_q      <= '0;
            res_off_q      <= '0;
        end else begin
            done_q <= 1'b0;
            if (nhit_d) begin
                neg_seen_q <= 1'b1;
            end else if (rise_d) begin
                neg_seen_q <= 1'b0;
            end
            // a closing sample that also hits the limit is a normal finish;
            // cnt_d equals the limit then, so total is cnt_d either way
            if (fin_meas_d) begin
                total_q   <= cnt_d;
                res_max_q <= max_d;
                res_min_q <= min_d;
                res_amp_q <= amp_d;
                res_off_q <= off_d;
                timeout_q <= !close_d;
                done_q    <= 1'b1;
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
            end
            if (start) begin
                n_q          <= (num_periods == 8'd0) ? 8'd1 : num_periods;
                sample_cnt_q <= '0;
                neg_seen_q   <= 1'b0;
                state_q      <= S_ARM;
                busy_q       <= 1'b1;
                if (!fin_meas_d) begin
                    timeout_q <= 1'b0;
                end
            end else begin
                case (state_q)
                    S_ARM: begin
                        if (sample_valid) begin
                            if (rise_d) begin
                                sample_cnt_q   <= '0;
                                crossing_cnt_q <= '0;
                                max_q          <= sample_data;
                                min_q          <= sample_data;
                                state_q        <= S_MEAS;
                            end else begin
                                sample_cnt_q <= cnt_d;
                                if (lim_d) begin
                                    total_q   <= cnt_d;
                                    res_max_q <= '0;
                                    res_min_q <= '0;
                                    res_amp_q <= '0;
                                    res_off_q <= '0;
                                    timeout_q <= 1'b1;
                                    done_q    <= 1'b1;
                                    state_q   <= S_IDLE;
                                    busy_q    <= 1'b0;
                                end
                            end
                        end
                    end
                    S_MEAS: begin
                        if (sample_valid && !fin_meas_d) begin
                            sample_cnt_q <= cnt_d;
                            max_q        <= max_d;
                            min_q        <= min_d;
                            if (rise_d) begin
                                crossing_cnt_q <= cross_d;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign timeout       = timeout_q;
    assign total_samples = total_q;
    assign max_code      = res_max_q;
    assign min_code      = res_min_q;
    assign amplitude     = res_amp_q;
    assign offset        = res_off_q;

endmodule

// File: tb/tb_sine_analyzer.sv
// tb_sine_analyzer: scoreboard bench for sine_analyzer.
// Main instance uses defaults; a CNT_W=8 instance covers the count limit.
module tb_sine_analyzer;

    localparam int W   = 12;
    localparam int H   = 8;
    localparam int CWA = 24;
    localparam int CWB = 8;

    typedef struct {
        int tot;
        int mx;
        int mn;
        int amp;
        int off;
        bit to;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic                a_start = 0, a_vld = 0;
    logic [7:0]          a_np = 0;
    logic signed [W-1:0] a_dat = 0;
    logic                a_busy, a_done, a_to;
    logic [CWA-1:0]      a_tot;
    logic signed [W-1:0] a_max, a_min, a_off;
    logic [W-1:0]        a_amp;

    logic                b_start = 0, b_vld = 0;
    logic [7:0]          b_np = 0;
    logic signed [W-1:0] b_dat = 0;
    logic                b_busy, b_done, b_to;
    logic [CWB-1:0]      b_tot;
    logic signed [W-1:0] b_max, b_min, b_off;
    logic [W-1:0]        b_amp;

    sine_analyzer #(.WIDTH(W), .CNT_W(CWA), .HYST(H)) u_a (
        .clk(clk), .reset_n(rst_n), .start(a_start),
        .num_periods(a_np), .sample_valid(a_vld),
        .sample_data(a_dat), .busy(a_busy), .done(a_done),
        .timeout(a_to), .total_samples(a_tot),
        .max_code(a_max), .min_code(a_min),
        .amplitude(a_amp), .offset(a_off)
    );

    sine_analyzer #(.WIDTH(W), .CNT_W(CWB), .HYST(H)) u_b (
        .clk(clk), .reset_n(rst_n), .start(b_start),
        .num_periods(b_np), .sample_valid(b_vld),
        .sample_data(b_dat), .busy(b_busy), .done(b_done),
        .timeout(b_to), .total_samples(b_tot),
        .max_code(b_max), .min_code(b_min),
        .amplitude(b_amp), .offset(b_off)
    );

    int   nvec = 0;
    int   nerr = 0;
    int   cca = 0;
    int   ccb = 0;
    int   stim[$];
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    function automatic void chk(string nm, int act, int req);
        nvec++;
        if (act != req) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, req);
        end
    endfunction

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        if (rst_n && a_done) begin
            if (qa.size() == 0) begin
                chk("A unexpected done", int'(a_done), 0);
            end else begin
                ea = qa.pop_front();
                chk("A total", int'(a_tot), ea.tot);
                chk("A max", int'($signed(a_max)), ea.mx);
                chk("A min", int'($signed(a_min)), ea.mn);
                chk("A amp", int'(a_amp), ea.amp);
                chk("A off", int'($signed(a_off)), ea.off);
                chk("A timeout", int'(a_to), int'(ea.to));
                chk("A latency", cyc, cca + 1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_done) begin
            if (qb.size() == 0) begin
                chk("B unexpected done", int'(b_done), 0);
            end else begin
                eb = qb.pop_front();
                chk("B total", int'(b_tot), eb.tot);
                chk("B max", int'($signed(b_max)), eb.mx);
                chk("B min", int'($signed(b_min)), eb.mn);
                chk("B amp", int'(b_amp), eb.amp);
                chk("B off", int'($signed(b_off)), eb.off);
                chk("B timeout", int'(b_to), int'(eb.to));
                chk("B latency", cyc, ccb + 1);
            end
        end
    end

    // ---------------- stimulus generation ----------------
    function automatic int wave(int kind, int i, int p, int a,
                                int off, int hi, int lo);
        int  ph;
        int  v;
        real x;
        ph = i % p;
        v  = 0;
        case (kind)
            0: begin
                if (ph <= p / 4) v = 4 * a * ph / p;
                else if (ph <= 3 * p / 4) v = 2 * a - 4 * a * ph / p;
                else v = 4 * a * ph / p - 4 * a;
                v = v + off;
            end
            1: v = (ph < p / 2) ? hi : lo;
            default: begin
                x = 2.0 * 3.14159265358979 * real'(ph) / real'(p);
                v = off + int'(real'(a) * $sin(x));
            end
        endcase
        return v;
    endfunction

    task automatic build(int kind, int p, int a, int off,
                         int hi, int lo, int len, int noise);
        int v;
        stim.delete();
        for (int i = 0; i < len; i++) begin
            v = wave(kind, i, p, a, off, hi, lo);
            if (noise > 0)
                v = v + int'($urandom_range(0, 2 * noise)) - noise;
            if (v > 2047) v = 2047;
            if (v < -2048) v = -2048;
            stim.push_back(v);
        end
    endtask

    // ---------------- reference model ----------------
    // Finds rising hysteresis crossings over the whole record,
    // then reads the result off the crossing positions.
    function automatic void model(input int n, input int cw,
                                  output exp_t e, output int kc,
                                  output bit ok);
        int xs[$];
        bit neg;
        int ne, lim, i0, kend, mx, mn;
        bit to;
        neg = 0;
        ne  = (n == 0) ? 1 : n;
        lim = (1 << cw) - 1;
        ok  = 0;
        kc  = -1;
        e   = '{default: 0};
        foreach (stim[i]) begin
            if (stim[i] <= -H) neg = 1;
            else if (stim[i] >= H && neg) begin
                xs.push_back(i);
                neg = 0;
            end
        end
        if (xs.size() == 0 || xs[0] > lim - 1) begin
            if (stim.size() >= lim) begin
                e.tot = lim;
                e.to  = 1;
                kc    = lim - 1;
                ok    = 1;
            end
            return;
        end
        i0 = xs[0];
        if (xs.size() > ne && xs[ne] - i0 <= lim) begin
            kend = xs[ne];
            to   = 0;
        end else if (stim.size() > i0 + lim) begin
            kend = i0 + lim;
            to   = 1;
        end else begin
            return;
        end
        mx = stim[i0];
        mn = stim[i0];
        for (int k = i0; k <= kend; k++) begin
            if (stim[k] > mx) mx = stim[k];
            if (stim[k] < mn) mn = stim[k];
        end
        e.tot = kend - i0;
        e.mx  = mx;
        e.mn  = mn;
        e.amp = (mx - mn) / 2;
        e.off = (mx + mn) >>> 1;
        e.to  = to;
        kc    = kend;
        ok    = 1;
    endfunction

    // ---------------- driver ----------------
    task automatic drive(bit b, bit st, int np, bit v, int d);
        if (b) begin
            b_start = st; b_np = 8'(np); b_vld = v; b_dat = 12'(d);
        end else begin
            a_start = st; a_np = 8'(np); a_vld = v; a_dat = 12'(d);
        end
    endtask

    task automatic run(bit b, int n, int vmode, bit push,
                       int stop_at, bit chain, int n2);
        exp_t e;
        int   kc, lim, ng, t;
        bit   ok;
        kc = -1;
        ok = 0;
        if (push) begin
            model(n, b ? CWB : CWA, e, kc, ok);
            if (!ok) begin
                $display("FAIL model: stimulus too short");
                nerr++;
            end else if (b) qb.push_back(e);
            else qa.push_back(e);
        end
        lim = stim.size();
        if (stop_at >= 0 && stop_at < lim) lim = stop_at;
        if (push && ok && kc + 3 < lim) lim = kc + 3;
        @(negedge clk);
        drive(b, 1'b1, n, 1'b0, 0);
        for (int i = 0; i < lim; i++) begin
            ng = (vmode == 1) ? 2 :
                 (vmode == 2) ? int'($urandom_range(0, 2)) : 0;
            repeat (ng) begin
                @(negedge clk);
                drive(b, 1'b0, n, 1'b0, 0);
            end
            @(negedge clk);
            if (chain && i == kc) drive(b, 1'b1, n2, 1'b1, stim[i]);
            else drive(b, 1'b0, n, 1'b1, stim[i]);
            if (i == kc) begin
                if (b) ccb = cyc;
                else cca = cyc;
            end
        end
        @(negedge clk);
        drive(b, 1'b0, n, 1'b0, 0);
        if (chain) chk("chain busy", int'(b ? b_busy : a_busy), 1);
        if (push) begin
            t = 0;
            while (t < 20 && (b ? qb.size() : qa.size()) != 0) begin
                @(negedge clk);
                t++;
            end
            chk(b ? "B done seen" : "A done seen",
                b ? qb.size() : qa.size(), 0);
        end
    endtask

    // ---------------- sequence ----------------
    initial begin
        int kind, p, a, off, noise, n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst busy", int'(a_busy), 0);
        chk("rst done", int'(a_done), 0);
        chk("rst timeout", int'(a_to), 0);
        chk("rst total", int'(a_tot), 0);
        chk("rst max", int'($signed(a_max)), 0);
        chk("rst min", int'($signed(a_min)), 0);
        chk("rst amp", int'(a_amp), 0);
        chk("rst off", int'($signed(a_off)), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        build(0, 100, 1000, 0, 0, 0, 750, 0);
        run(0, 4, 0, 1, -1, 0, 0);
        run(0, 4, 1, 1, -1, 0, 0);

        build(2, 64, 500, 200, 0, 0, 300, 0);
        run(0, 0, 0, 1, -1, 0, 0);

        build(1, 10, 0, 0, 2047, -2048, 80, 0);
        run(0, 3, 0, 1, -1, 0, 0);

        stim.delete();
        for (int i = 0; i < 300; i++)
            stim.push_back((i % 2 == 0) ? (H - 1) : -(H - 1));
        run(1, 1, 0, 1, -1, 0, 0);

        build(0, 100, 1000, 0, 0, 0, 750, 0);
        run(1, 4, 0, 1, -1, 0, 0);

        build(0, 85, 1000, 0, 0, 0, 500, 0);
        run(1, 3, 0, 1, -1, 0, 0);

        build(0, 50, 900, 30, 0, 0, 400, 0);
        run(0, 3, 0, 0, 150, 0, 0);
        build(0, 50, 700, -40, 0, 0, 400, 0);
        run(0, 2, 2, 1, -1, 0, 0);

        build(0, 40, 600, 0, 0, 0, 300, 0);
        run(0, 2, 0, 1, -1, 1, 1);

        build(0, 50, 800, 0, 0, 0, 400, 0);
        run(0, 4, 0, 0, 120, 0, 0);
        rst_n = 1'b0;
        #1;
        chk("midrst busy", int'(a_busy), 0);
        chk("midrst done", int'(a_done), 0);
        chk("midrst total", int'(a_tot), 0);
        chk("midrst max", int'($signed(a_max)), 0);
        chk("midrst amp", int'(a_amp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int r = 0; r < 12; r++) begin
            kind  = int'($urandom_range(0, 2));
            p     = int'($urandom_range(8, 80));
            a     = int'($urandom_range(50, 1500));
            off   = int'($urandom_range(0, a)) - a / 2;
            noise = ($urandom_range(0, 3) == 0)
                  ? int'($urandom_range(1, 6)) : 0;
            n     = int'($urandom_range(0, 4));
            build(kind, p, a, off, off + a, off - a,
                  (n + 4) * p + 50, noise);
            run(0, n, int'($urandom_range(0, 2)), 1, -1, 0, 0);
        end

        repeat (5) @(negedge clk);
        chk("A pending", qa.size(), 0);
        chk("B pending", qb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 nvec, nerr);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

endmodule
